branch_predict_ctrl: RTL and testbench

- Sequences the memory-access branch resolution path of the VLIW core: supplies the taken/not-taken prediction at fetch and consumes the resolved outcome from slot-1's M stage.
- On mispredict, redirects fetch to the correct destination and drives a timed pipeline flush.
- Holds a 2-bit saturating-counter branch history table (BHT) plus branch and mispredict statistics counters.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bht_table.sv | 36 +++
 rtl/branch_predict_ctrl.sv | 105 ++++++++++
 tb/tb_branch_predict_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: FSM states,
// 2-bit counter encodings and the saturating update rule.
package bp_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] BHT_RESET = CTR_WNT;

   // Move one step toward the observed outcome, pinning at either end.
   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with one
// combinational read port and one saturating-update write port.
module bht_table
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [1:0]          rd_ctr,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_taken
);

   localparam int DEPTH = 1 << IDX_BITS;

   logic [1:0] ctr_q [DEPTH];

   // NOTE: every entry needs a known value out of reset, so this is a flop
   // array with a reset loop rather than an inferred RAM, which cannot reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i] <= BHT_RESET;
         end
      end else if (wr_en) begin
         ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
      end
   end

   // Read sees the pre-update value when the same entry is written this cycle.
   assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: BHT lookup at fetch, outcome update from
// slot-1 M stage, mispredict redirect, timed flush and statistics.
module branch_predict_ctrl
   import bp_pkg::*;
#(
   parameter int IDX_BITS     = 6,
   parameter int FLUSH_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_F,
   output logic        predict_F,
   input  logic        resolve_valid_M,
   input  logic [31:0] resolve_pc_M,
   input  logic        predicted_M,
   input  logic        taken_M,
   input  logic [31:0] dest_M,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t     state, state_next;
   logic [3:0] flush_cnt, flush_cnt_next;
   logic       accept;
   logic       mispredict;
   logic [1:0] rd_ctr;

   // Only the index bits of each PC select a table entry.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_F[31:IDX_BITS+2], pc_F[1:0],
                             resolve_pc_M[31:IDX_BITS+2], resolve_pc_M[1:0]};

   // Wrong-path resolutions arriving during FLUSH are dropped here.
   assign accept     = (state == IDLE) && resolve_valid_M;
   assign mispredict = accept && (predicted_M != taken_M);

   bht_table #(
      .IDX_BITS(IDX_BITS)
   ) u_bht (
      .clk      (clk),
      .rstn     (rstn),
      .rd_idx   (pc_F[IDX_BITS+1:2]),
      .rd_ctr   (rd_ctr),
      .wr_en    (accept),
      .wr_idx   (resolve_pc_M[IDX_BITS+1:2]),
      .wr_taken (taken_M)
   );

   assign predict_F = rd_ctr[1];

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      unique case (state)
         IDLE: begin
            if (mispredict) begin
               state_next     = FLUSH;
               flush_cnt_next = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (flush_cnt == 4'd0) begin
               state_next = IDLE;
            end else begin
               flush_cnt_next = flush_cnt - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= IDLE;
         flush_cnt        <= 4'd0;
         flush            <= 1'b0;
         redirect         <= 1'b0;
         redirect_pc      <= 32'd0;
         branch_count     <= 32'd0;
         mispredict_count <= 32'd0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
         flush     <= (state_next == FLUSH);
         redirect  <= mispredict;
         if (mispredict) begin
            redirect_pc      <= dest_M;
            mispredict_count <= mispredict_count + 32'd1;
         end
         if (accept) begin
            branch_count <= branch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl: reset, training,
// mispredict redirect/flush, wrong-path suppression, collision, async reset.
module tb_branch_predict_ctrl;
   logic        clk;
   logic        rstn;
   logic [31:0] pc_F;
   logic        predict_F;
   logic        resolve_valid_M;
   logic [31:0] resolve_pc_M;
   logic        predicted_M;
   logic        taken_M;
   logic [31:0] dest_M;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] exp_br  = 0;
   logic [31:0] exp_mis = 0;
   int flush_len, redir_len;

   branch_predict_ctrl #(.IDX_BITS(6), .FLUSH_CYCLES(3)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .pc_F             (pc_F),
      .predict_F        (predict_F),
      .resolve_valid_M  (resolve_valid_M),
      .resolve_pc_M     (resolve_pc_M),
      .predicted_M      (predicted_M),
      .taken_M          (taken_M),
      .dest_M           (dest_M),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle resolution; returns 1 time unit after the capturing edge.
   task automatic resolve(input logic [31:0] pc, input logic pred,
                          input logic tkn, input logic [31:0] dest);
      resolve_valid_M = 1'b1;
      resolve_pc_M    = pc;
      predicted_M     = pred;
      taken_M         = tkn;
      dest_M          = dest;
      tick();
      resolve_valid_M = 1'b0;
   endtask

   // Counts flush/redirect cycles starting from the current (sampled) cycle.
   task automatic measure_flush(output int f_len, output int r_len);
      int budget;
      f_len  = 0;
      r_len  = 0;
      budget = 0;
      while (flush === 1'b1 && budget < 20) begin
         f_len++;
         if (redirect === 1'b1) r_len++;
         tick();
         budget++;
      end
      if (budget >= 20) begin
         n_total++;
         $display("FAIL flush_timeout: flush still %b after %0d cycles, required 0", flush, budget);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      pc_F = 32'h40;
      #2;
      n_total++; if (predict_F !== 1'b0) $display("FAIL reset_predict: got %b want 0", predict_F); else n_pass++;
      n_total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else n_pass++;
      n_total++; if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect); else n_pass++;
      n_total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); else n_pass++;
      n_total++; if (branch_count !== 32'h0) $display("FAIL reset_branch_count: got %0d want 0", branch_count); else n_pass++;
      n_total++; if (mispredict_count !== 32'h0) $display("FAIL reset_mispredict_count: got %0d want 0", mispredict_count); else n_pass++;
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   // Entry 16 trains 01 -> 10 -> 11 -> 11; only the first prediction is wrong.
   task automatic test_correct_predictions();
      logic preds [4];
      preds[0] = 1'b0; preds[1] = 1'b1; preds[2] = 1'b1; preds[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         resolve(32'h40, preds[i], 1'b1, 32'h100);
         exp_br++;
         if (preds[i] != 1'b1) exp_mis++;
         measure_flush(flush_len, redir_len);
      end
      pc_F = 32'h40;
      #1;
      n_total++; if (predict_F !== 1'b1) $display("FAIL train_predict: got %b want 1", predict_F); else n_pass++;
      n_total++; if (branch_count !== exp_br) $display("FAIL train_branch_count: got %0d want %0d", branch_count, exp_br); else n_pass++;
      n_total++; if (mispredict_count !== exp_mis) $display("FAIL train_mispredict_count: got %0d want %0d", mispredict_count, exp_mis); else n_pass++;
      n_total++; if (redirect_pc !== 32'h100) $display("FAIL train_redirect_pc: got %h want 00000100", redirect_pc); else n_pass++;
   endtask

   // Entry 16 is 11; one not-taken drops it to 10, which still predicts taken.
   task automatic test_mispredict();
      n_total++; if (redirect !== 1'b0) $display("FAIL mis_redirect_before: got %b want 0", redirect); else n_pass++;
      resolve(32'h40, 1'b1, 1'b0, 32'h1234);
      exp_br++; exp_mis++;
      n_total++; if (redirect !== 1'b1) $display("FAIL mis_redirect: got %b want 1", redirect); else n_pass++;
      n_total++; if (redirect_pc !== 32'h1234) $display("FAIL mis_redirect_pc: got %h want 00001234", redirect_pc); else n_pass++;
      n_total++; if (mispredict_count !== exp_mis) $display("FAIL mis_count: got %0d want %0d", mispredict_count, exp_mis); else n_pass++;
      measure_flush(flush_len, redir_len);
      n_total++; if (flush_len !== 3) $display("FAIL mis_flush_len: got %0d want 3", flush_len); else n_pass++;
      n_total++; if (redir_len !== 1) $display("FAIL mis_redirect_len: got %0d want 1", redir_len); else n_pass++;
      n_total++; if (redirect_pc !== 32'h1234) $display("FAIL mis_redirect_pc_hold: got %h want 00001234", redirect_pc); else n_pass++;
      pc_F = 32'h40;
      #1;
      n_total++; if (predict_F !== 1'b1) $display("FAIL mis_entry_10: got %b want 1", predict_F); else n_pass++;
   endtask

   // Entry 48 goes 01 -> 00; three ignored taken resolutions would have made it 11.
   task automatic test_wrong_path();
      resolve(32'hC0, 1'b1, 1'b0, 32'h2000);
      exp_br++; exp_mis++;
      resolve_valid_M = 1'b1;
      resolve_pc_M    = 32'hC0;
      predicted_M     = 1'b0;
      taken_M         = 1'b1;
      dest_M          = 32'hDEAD;
      measure_flush(flush_len, redir_len);
      // First IDLE cycle after FLUSH: a correct not-taken resolution.
      resolve(32'hC0, 1'b0, 1'b0, 32'hC4);
      exp_br++;
      pc_F = 32'hC0;
      #1;
      n_total++; if (flush_len !== 3) $display("FAIL wp_flush_len: got %0d want 3", flush_len); else n_pass++;
      n_total++; if (redir_len !== 1) $display("FAIL wp_redirect_len: got %0d want 1", redir_len); else n_pass++;
      n_total++; if (branch_count !== exp_br) $display("FAIL wp_branch_count: got %0d want %0d", branch_count, exp_br); else n_pass++;
      n_total++; if (mispredict_count !== exp_mis) $display("FAIL wp_mispredict_count: got %0d want %0d", mispredict_count, exp_mis); else n_pass++;
      n_total++; if (redirect_pc !== 32'h2000) $display("FAIL wp_redirect_pc: got %h want 00002000", redirect_pc); else n_pass++;
      n_total++; if (predict_F !== 1'b0) $display("FAIL wp_table: got %b want 0", predict_F); else n_pass++;
      n_total++; if (redirect !== 1'b0 || flush !== 1'b0) $display("FAIL wp_after_accept: got redirect=%b flush=%b want 0/0", redirect, flush); else n_pass++;
   endtask

   task automatic test_collision();
      pc_F            = 32'h80;
      resolve_valid_M = 1'b1;
      resolve_pc_M    = 32'h80;
      predicted_M     = 1'b0;
      taken_M         = 1'b1;
      dest_M          = 32'h200;
      #1;
      n_total++; if (predict_F !== 1'b0) $display("FAIL coll_same_cycle: got %b want 0", predict_F); else n_pass++;
      tick();
      resolve_valid_M = 1'b0;
      exp_br++; exp_mis++;
      n_total++; if (predict_F !== 1'b1) $display("FAIL coll_next_cycle: got %b want 1", predict_F); else n_pass++;
      measure_flush(flush_len, redir_len);
      n_total++; if (branch_count !== exp_br) $display("FAIL coll_branch_count: got %0d want %0d", branch_count, exp_br); else n_pass++;
   endtask

   task automatic test_async_reset();
      resolve(32'h40, 1'b1, 1'b0, 32'h3000);
      pc_F = 32'h80;
      #1;
      n_total++; if (predict_F !== 1'b1 || flush !== 1'b1) $display("FAIL ar_precondition: got predict=%b flush=%b want 1/1", predict_F, flush); else n_pass++;
      tick();
      #3 rstn = 1'b0;
      #1;
      n_total++; if (flush !== 1'b0) $display("FAIL ar_flush: got %b want 0", flush); else n_pass++;
      n_total++; if (redirect !== 1'b0) $display("FAIL ar_redirect: got %b want 0", redirect); else n_pass++;
      n_total++; if (predict_F !== 1'b0) $display("FAIL ar_bht_entry: got %b want 0", predict_F); else n_pass++;
      n_total++; if (branch_count !== 32'h0 || mispredict_count !== 32'h0) $display("FAIL ar_counts: got %0d/%0d want 0/0", branch_count, mispredict_count); else n_pass++;
      n_total++; if (redirect_pc !== 32'h0) $display("FAIL ar_redirect_pc: got %h want 0", redirect_pc); else n_pass++;
      #2 rstn = 1'b1;
      tick();
      resolve(32'h80, 1'b0, 1'b0, 32'h84);
      n_total++; if (branch_count !== 32'd1) $display("FAIL ar_idle_accept: got %0d want 1", branch_count); else n_pass++;
      n_total++; if (flush !== 1'b0 || redirect !== 1'b0) $display("FAIL ar_idle_quiet: got flush=%b redirect=%b want 0/0", flush, redirect); else n_pass++;
   endtask

   initial begin
      rstn            = 1'b0;
      pc_F            = 32'h0;
      resolve_valid_M = 1'b0;
      resolve_pc_M    = 32'h0;
      predicted_M     = 1'b0;
      taken_M         = 1'b0;
      dest_M          = 32'h0;
      test_reset();
      test_correct_predictions();
      test_mispredict();
      test_wrong_path();
      test_collision();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
